// File: rtl/alt_vipcti130_common_pkg.sv
// Shared types and helpers for the clocked-video timing path: region enum, default widths and
// a saturating adder used when precomputing region boundaries.
package alt_vipcti130_common_pkg;

  localparam int unsigned HWidth  = 14;
  localparam int unsigned VWidth  = 13;
  localparam int unsigned FcWidth = 16;

  typedef enum logic [1:0] {
    RegActive = 2'd0,
    RegFp     = 2'd1,
    RegSync   = 2'd2,
    RegBp     = 2'd3
  } region_e;

  // Adds two unsigned values and clamps the result to 2^width - 1.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/alt_vipcti130_common_sync_generator_if.sv
// Timing-update handshake between a configuration source (master) and the sync generator
// (slave): region lengths and sync polarities offered with valid/ready.
interface alt_vipcti130_common_sync_generator_if #(
    parameter int unsigned H_WIDTH = 14,
    parameter int unsigned V_WIDTH = 13
);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [H_WIDTH-1:0] cfg_h_active;
    logic [H_WIDTH-1:0] cfg_h_fp;
    logic [H_WIDTH-1:0] cfg_h_sync;
    logic [V_WIDTH-1:0] cfg_v_active;
    logic [V_WIDTH-1:0] cfg_v_fp;
    logic [V_WIDTH-1:0] cfg_v_sync;
    logic               cfg_h_pol;
    logic               cfg_v_pol;

    modport master (
        output cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync,
        output cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_h_pol, cfg_v_pol,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync,
        input  cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_h_pol, cfg_v_pol,
        output cfg_ready
    );

endinterface

// File: rtl/alt_vipcti130_common_region_fsm.sv
// One-axis region tracker: classifies a raster count into active / front porch / sync / back
// porch against boundaries that are latched (saturated) whenever new lengths are loaded.
module alt_vipcti130_common_region_fsm
    import alt_vipcti130_common_pkg::*;
#(
    parameter int unsigned Width = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [Width-1:0] count_i,
    input  logic [Width-1:0] len_active_i,
    input  logic [Width-1:0] len_fp_i,
    input  logic [Width-1:0] len_sync_i,
    output region_e          state_o
);

    function automatic logic [Width-1:0] add_sat(input logic [Width-1:0] a,
                                                 input logic [Width-1:0] b);
        logic [31:0] r;
        r = sat_add(32'(a), 32'(b), Width);
        return r[Width-1:0];
    endfunction

    logic [Width-1:0] b1_q, b2_q, b3_q;
    logic [Width-1:0] b1_d, b2_d, b3_d;
    logic [Width-1:0] nb1, nb2, nb3;
    logic [Width-1:0] eb1, eb2, eb3;
    region_e          state_q, state_d;

    always_comb begin
        nb1 = len_active_i;
        nb2 = add_sat(nb1, len_fp_i);
        nb3 = add_sat(nb2, len_sync_i);
    end

    // The load cycle itself already classifies against the new boundaries.
    always_comb begin
        eb1 = load_i ? nb1 : b1_q;
        eb2 = load_i ? nb2 : b2_q;
        eb3 = load_i ? nb3 : b3_q;
        b1_d = eb1;
        b2_d = eb2;
        b3_d = eb3;
    end

    always_comb begin
        state_d = state_q;
        if (sclr) begin
            state_d = RegBp;
        end else if (enable_i) begin
            if (count_i < eb1) begin
                state_d = RegActive;
            end else if (count_i < eb2) begin
                state_d = RegFp;
            end else if (count_i < eb3) begin
                state_d = RegSync;
            end else begin
                state_d = RegBp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RegBp;
            b1_q    <= '0;
            b2_q    <= '0;
            b3_q    <= '0;
        end else begin
            state_q <= state_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            b3_q    <= b3_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alt_vipcti130_common_sync_generator.sv
// Registered video timing (syncs, DE, blanking, SOF) from the frame counter's raster position,
// with frame-aligned timing updates. ALT_VIPCTI130_SYNC_POLARITY_EN enables sync polarity.
module alt_vipcti130_common_sync_generator
    import alt_vipcti130_common_pkg::*;
#(
    parameter int unsigned H_WIDTH  = HWidth,
    parameter int unsigned V_WIDTH  = VWidth,
    parameter int unsigned FC_WIDTH = FcWidth
) (
    input  logic                rst,
    input  logic                clk,
    input  logic                sclr,
    input  logic                enable,
    input  logic                new_line,
    input  logic [H_WIDTH-1:0]  h_count,
    input  logic [V_WIDTH-1:0]  v_count,
    alt_vipcti130_common_sync_generator_if.slave cfg,
    output logic                h_sync,
    output logic                v_sync,
    output logic                de,
    output logic                h_blank,
    output logic                v_blank,
    output logic                sof,
    output logic                eol,
    output logic [FC_WIDTH-1:0] frame_count,
    output logic                cfg_applied
);

    logic cap_h_pol, cap_v_pol;
`ifdef ALT_VIPCTI130_SYNC_POLARITY_EN
    assign cap_h_pol = cfg.cfg_h_pol;
    assign cap_v_pol = cfg.cfg_v_pol;
`else
    assign cap_h_pol = 1'b0;
    assign cap_v_pol = 1'b0;
`endif

    logic               pend_q, pend_d;
    logic [H_WIDTH-1:0] pend_h_active_q, pend_h_fp_q, pend_h_sync_q;
    logic [H_WIDTH-1:0] pend_h_active_d, pend_h_fp_d, pend_h_sync_d;
    logic [V_WIDTH-1:0] pend_v_active_q, pend_v_fp_q, pend_v_sync_q;
    logic [V_WIDTH-1:0] pend_v_active_d, pend_v_fp_d, pend_v_sync_d;
    logic               pend_h_pol_q, pend_v_pol_q, pend_h_pol_d, pend_v_pol_d;
    logic               h_pol_q, v_pol_q, h_pol_d, v_pol_d;
    logic               prev_vnz_q, prev_vnz_d;
    logic               sof_q, sof_d;
    logic               eol_q, eol_d;
    logic               applied_q, applied_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;

    logic    sof_det, apply, xfer;
    region_e h_state, v_state;

    assign sof_det = enable && (h_count == '0) && (v_count == '0) && prev_vnz_q;
    assign apply   = sof_det && pend_q && !sclr;
    assign xfer    = cfg.cfg_valid && !pend_q && !sclr;

    always_comb begin
        pend_d          = pend_q;
        pend_h_active_d = pend_h_active_q;
        pend_h_fp_d     = pend_h_fp_q;
        pend_h_sync_d   = pend_h_sync_q;
        pend_v_active_d = pend_v_active_q;
        pend_v_fp_d     = pend_v_fp_q;
        pend_v_sync_d   = pend_v_sync_q;
        pend_h_pol_d    = pend_h_pol_q;
        pend_v_pol_d    = pend_v_pol_q;
        h_pol_d         = h_pol_q;
        v_pol_d         = v_pol_q;
        prev_vnz_d      = prev_vnz_q;
        sof_d           = 1'b0;
        eol_d           = 1'b0;
        applied_d       = 1'b0;
        fc_d            = fc_q;
        if (sclr) begin
            pend_d     = 1'b0;
            prev_vnz_d = 1'b1;
            fc_d       = '0;
        end else begin
            if (enable) begin
                prev_vnz_d = (v_count != '0);
            end
            sof_d     = sof_det;
            eol_d     = enable && new_line;
            applied_d = apply;
            fc_d      = fc_q + {{(FC_WIDTH-1){1'b0}}, sof_det};
            if (apply) begin
                pend_d  = 1'b0;
                h_pol_d = pend_h_pol_q;
                v_pol_d = pend_v_pol_q;
            end
            // Only reachable with nothing pending, so never collides with apply.
            if (xfer) begin
                pend_d          = 1'b1;
                pend_h_active_d = cfg.cfg_h_active;
                pend_h_fp_d     = cfg.cfg_h_fp;
                pend_h_sync_d   = cfg.cfg_h_sync;
                pend_v_active_d = cfg.cfg_v_active;
                pend_v_fp_d     = cfg.cfg_v_fp;
                pend_v_sync_d   = cfg.cfg_v_sync;
                pend_h_pol_d    = cap_h_pol;
                pend_v_pol_d    = cap_v_pol;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q          <= 1'b0;
            pend_h_active_q <= '0;
            pend_h_fp_q     <= '0;
            pend_h_sync_q   <= '0;
            pend_v_active_q <= '0;
            pend_v_fp_q     <= '0;
            pend_v_sync_q   <= '0;
            pend_h_pol_q    <= 1'b0;
            pend_v_pol_q    <= 1'b0;
            h_pol_q         <= 1'b0;
            v_pol_q         <= 1'b0;
            prev_vnz_q      <= 1'b1;
            sof_q           <= 1'b0;
            eol_q           <= 1'b0;
            applied_q       <= 1'b0;
            fc_q            <= '0;
        end else begin
            pend_q          <= pend_d;
            pend_h_active_q <= pend_h_active_d;
            pend_h_fp_q     <= pend_h_fp_d;
            pend_h_sync_q   <= pend_h_sync_d;
            pend_v_active_q <= pend_v_active_d;
            pend_v_fp_q     <= pend_v_fp_d;
            pend_v_sync_q   <= pend_v_sync_d;
            pend_h_pol_q    <= pend_h_pol_d;
            pend_v_pol_q    <= pend_v_pol_d;
            h_pol_q         <= h_pol_d;
            v_pol_q         <= v_pol_d;
            prev_vnz_q      <= prev_vnz_d;
            sof_q           <= sof_d;
            eol_q           <= eol_d;
            applied_q       <= applied_d;
            fc_q            <= fc_d;
        end
    end

    alt_vipcti130_common_region_fsm #(
        .Width (H_WIDTH)
    ) u_h_fsm (
        .clk          (clk),
        .rst          (rst),
        .sclr         (sclr),
        .enable_i     (enable),
        .load_i       (apply),
        .count_i      (h_count),
        .len_active_i (pend_h_active_q),
        .len_fp_i     (pend_h_fp_q),
        .len_sync_i   (pend_h_sync_q),
        .state_o      (h_state)
    );

    alt_vipcti130_common_region_fsm #(
        .Width (V_WIDTH)
    ) u_v_fsm (
        .clk          (clk),
        .rst          (rst),
        .sclr         (sclr),
        .enable_i     (enable),
        .load_i       (apply),
        .count_i      (v_count),
        .len_active_i (pend_v_active_q),
        .len_fp_i     (pend_v_fp_q),
        .len_sync_i   (pend_v_sync_q),
        .state_o      (v_state)
    );

    assign cfg.cfg_ready = !pend_q;
    assign de            = (h_state == RegActive) && (v_state == RegActive);
    assign h_blank       = (h_state != RegActive);
    assign v_blank       = (v_state != RegActive);
    assign h_sync        = (h_state == RegSync) ^ h_pol_q;
    assign v_sync        = (v_state == RegSync) ^ v_pol_q;
    assign sof           = sof_q;
    assign eol           = eol_q;
    assign cfg_applied   = applied_q;
    assign frame_count   = fc_q;

endmodule

// File: tb/tb_alt_vipcti130_common_sync_generator.sv
// Directed bench for the sync generator: 720p region edges, mid-frame update, zero front
// porch, enable gating, sclr with a pending update, polarity and asynchronous reset.
module tb_alt_vipcti130_common_sync_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclr;
    logic        enable;
    logic        new_line;
    logic [13:0] h_count;
    logic [12:0] v_count;
    logic        h_sync, v_sync, de, h_blank, v_blank, sof, eol, cfg_applied;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;

    alt_vipcti130_common_sync_generator_if #(.H_WIDTH(14), .V_WIDTH(13)) cfg_if ();

    alt_vipcti130_common_sync_generator dut (
        .rst         (rst),
        .clk         (clk),
        .sclr        (sclr),
        .enable      (enable),
        .new_line    (new_line),
        .h_count     (h_count),
        .v_count     (v_count),
        .cfg         (cfg_if),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .de          (de),
        .h_blank     (h_blank),
        .v_blank     (v_blank),
        .sof         (sof),
        .eol         (eol),
        .frame_count (frame_count),
        .cfg_applied (cfg_applied)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v, input logic en, input logic nl);
        h_count  = h[13:0];
        v_count  = v[12:0];
        enable   = en;
        new_line = nl;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ha, input int hf, input int hs, input int va, input int vf,
                           input int vs, input logic hp, input logic vp);
        cfg_if.cfg_h_active = ha[13:0];
        cfg_if.cfg_h_fp     = hf[13:0];
        cfg_if.cfg_h_sync   = hs[13:0];
        cfg_if.cfg_v_active = va[12:0];
        cfg_if.cfg_v_fp     = vf[12:0];
        cfg_if.cfg_v_sync   = vs[12:0];
        cfg_if.cfg_h_pol    = hp;
        cfg_if.cfg_v_pol    = vp;
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, de_cnt, vs_cnt, vs_first, vb_cnt, sof_cnt, hold_err;
        logic [4:0] saved;
        logic       exp_idle, exp_pulse;

        rst = 1'b1; sclr = 1'b0; enable = 1'b0; new_line = 1'b0;
        h_count = '0; v_count = '0;
        cfg_if.cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_de", de, 0);
        chk("rst_h_blank", h_blank, 1);
        chk("rst_v_blank", v_blank, 1);
        chk("rst_h_sync", h_sync, 0);
        chk("rst_v_sync", v_sync, 0);
        chk("rst_sof", sof, 0);
        chk("rst_eol", eol, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);
        chk("rst_applied", cfg_applied, 0);
        rst = 1'b0;

        // 720p: h 1280/110/40 (total 1650), v 720/5/5 (total 750)
        set_cfg(1280, 110, 40, 720, 5, 5, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        step(0, 0, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        chk("p720_ready_low", cfg_if.cfg_ready, 0);
        step(0, 0, 1'b1, 1'b0);
        chk("p720_sof", sof, 1);
        chk("p720_applied", cfg_applied, 1);
        chk("p720_fc", frame_count, 1);
        chk("p720_de0", de, 1);
        chk("p720_ready_back", cfg_if.cfg_ready, 1);
        hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 1;
        for (int h = 1; h < 1650; h++) begin
            step(h, 0, 1'b1, h == 1649);
            if (h_sync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = h;
                hs_last = h;
            end
            if (de) de_cnt++;
        end
        chk("p720_hs_cnt", hs_cnt, 40);
        chk("p720_hs_first", hs_first, 1390);
        chk("p720_hs_last", hs_last, 1429);
        chk("p720_de_cnt", de_cnt, 1280);
        chk("p720_eol", eol, 1);
        vs_cnt = 0; vs_first = -1; vb_cnt = 0;
        for (int v = 1; v < 750; v++) begin
            step(0, v, 1'b1, 1'b0);
            if (v_sync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = v;
            end
            if (v_blank) vb_cnt++;
        end
        chk("p720_vs_cnt", vs_cnt, 5);
        chk("p720_vs_first", vs_first, 725);
        chk("p720_vb_cnt", vb_cnt, 30);
        step(0, 0, 1'b1, 1'b0);
        chk("p720_sof2", sof, 1);
        chk("p720_fc2", frame_count, 2);
        chk("p720_no_apply", cfg_applied, 0);

        // Mid-frame update to h 8/2/3 v 4/1/2
        set_cfg(8, 2, 3, 4, 1, 2, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        step(0, 300, 1'b1, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        chk("mid_ready_low", cfg_if.cfg_ready, 0);
        step(1000, 300, 1'b1, 1'b0);
        chk("mid_old_de", de, 1);
        chk("mid_no_apply", cfg_applied, 0);
        step(1395, 300, 1'b1, 1'b0);
        chk("mid_old_hs", h_sync, 1);
        step(0, 0, 1'b1, 1'b0);
        chk("mid_sof", sof, 1);
        chk("mid_applied", cfg_applied, 1);
        chk("mid_fc", frame_count, 3);
        chk("mid_ready", cfg_if.cfg_ready, 1);
        chk("mid_de_line0", de, 1);
        step(8, 0, 1'b1, 1'b0);
        chk("mid_new_de_edge", de, 0);

        // Full small frame (16 x 9)
        step(0, 5, 1'b1, 1'b0);
        de_cnt = 0; sof_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int v = 0; v < 9; v++) begin
            for (int h = 0; h < 16; h++) begin
                step(h, v, 1'b1, h == 15);
                if (de) de_cnt++;
                if (sof) sof_cnt++;
                if (h_sync) hs_cnt++;
                if (v_sync) vs_cnt++;
            end
        end
        chk("small_de_cnt", de_cnt, 32);
        chk("small_sof_cnt", sof_cnt, 1);
        chk("small_hs_cnt", hs_cnt, 27);
        chk("small_vs_cnt", vs_cnt, 32);
        chk("small_fc", frame_count, 4);

        // Zero front porch: h 8/0/3
        set_cfg(8, 0, 3, 4, 1, 2, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        step(0, 5, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        step(0, 0, 1'b1, 1'b0);
        chk("zfp_applied", cfg_applied, 1);
        hs_cnt = 0; hs_first = -1;
        for (int h = 1; h < 16; h++) begin
            step(h, 1, 1'b1, 1'b0);
            if (h_sync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = h;
            end
        end
        chk("zfp_hs_first", hs_first, 8);
        chk("zfp_hs_cnt", hs_cnt, 3);

        // enable at 50%: idle cycles hold outputs, pulses stay low
        step(0, 5, 1'b1, 1'b0);
        hold_err = 0; sof_cnt = 0;
        for (int v = 0; v < 9; v++) begin
            for (int h = 0; h < 16; h++) begin
                step(h, v, 1'b1, 1'b0);
                if (sof) sof_cnt++;
                saved = {h_sync, v_sync, de, h_blank, v_blank};
                step(h, v, 1'b0, 1'b1);
                if ({h_sync, v_sync, de, h_blank, v_blank} !== saved) hold_err++;
                if (sof || eol || cfg_applied) hold_err++;
            end
        end
        chk("en50_hold", hold_err, 0);
        chk("en50_sof_cnt", sof_cnt, 1);
        chk("en50_fc", frame_count, 6);

        // sclr mid-frame with an update pending
        set_cfg(2, 1, 1, 2, 1, 1, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        step(3, 2, 1'b1, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        chk("sclr_ready_low", cfg_if.cfg_ready, 0);
        chk("sclr_de_before", de, 1);
        sclr = 1'b1;
        step(3, 2, 1'b1, 1'b0);
        sclr = 1'b0;
        chk("sclr_de", de, 0);
        chk("sclr_h_blank", h_blank, 1);
        chk("sclr_v_blank", v_blank, 1);
        chk("sclr_h_sync", h_sync, 0);
        chk("sclr_ready", cfg_if.cfg_ready, 1);
        chk("sclr_fc", frame_count, 0);
        chk("sclr_sof", sof, 0);
        step(0, 0, 1'b1, 1'b0);
        chk("sclr_sof_after", sof, 1);
        chk("sclr_no_apply", cfg_applied, 0);
        chk("sclr_fc_after", frame_count, 1);
        step(5, 0, 1'b1, 1'b0);
        chk("sclr_old_timing", de, 1);

        // Polarity
`ifdef ALT_VIPCTI130_SYNC_POLARITY_EN
        exp_idle = 1'b1; exp_pulse = 1'b0;
`else
        exp_idle = 1'b0; exp_pulse = 1'b1;
`endif
        set_cfg(8, 0, 3, 4, 1, 2, 1'b1, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        step(0, 5, 1'b0, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        step(0, 5, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        chk("pol_applied", cfg_applied, 1);
        chk("pol_fc", frame_count, 2);
        chk("pol_idle", h_sync, exp_idle);
        step(8, 0, 1'b1, 1'b0);
        chk("pol_pulse", h_sync, exp_pulse);
        step(12, 0, 1'b1, 1'b0);
        chk("pol_idle_after", h_sync, exp_idle);
        chk("pol_v_sync", v_sync, 0);

        // Asynchronous reset mid-frame
        step(3, 1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fc", frame_count, 0);
        chk("arst_de", de, 0);
        chk("arst_h_blank", h_blank, 1);
        chk("arst_h_sync", h_sync, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
